y_axis_pack_writer: RTL and testbench

- Sink for the gate-output stream y_t (y_axis) leaving the EW/gate pipeline.
- Accepts TILE_SIZE-lane vector tiles and packs them into DATA_W-bit words.
- Writes each word to the output SRAM bank through a valid/ready write port and counts tokens.
- Signals per-token and per-run completion to the host-side controller.

---
 rtl/ypack_pkg.sv | 36 +++
 rtl/ypack_tile_packer.sv | 83 ++++++++
 rtl/y_axis_pack_writer.sv | 169 ++++++++++++++++
 tb/tb_y_axis_pack_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ypack_pkg.sv
// -----------------------------------------------------------------------------
// ypack_pkg
// Shared definitions for the y_axis pack writer:
//   - derived-constant functions (tiles per word, tiles per token, words per token)
//   - FSM state enum
//   - tile slot offset helper (bit position of tile slot k inside a word)
// -----------------------------------------------------------------------------
package ypack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Tiles per memory word.
    function automatic int calc_tpw(int data_w, int tile_size, int data_width);
        return data_w / (tile_size * data_width);
    endfunction

    // Tiles per token.
    function automatic int calc_tpt(int d, int tile_size);
        return d / tile_size;
    endfunction

    // Words per token.
    function automatic int calc_wpt(int tpt, int tpw);
        return tpt / tpw;
    endfunction

    // LSB of tile slot k in a packed word; slot 0 holds the first tile received.
    function automatic int tile_slot_lsb(int k, int tile_w);
        return k * tile_w;
    endfunction

endpackage

// File: rtl/ypack_tile_packer.sv
// -----------------------------------------------------------------------------
// ypack_tile_packer
// Collects TPW consecutive tiles into one DATA_W-bit word and presents it on a
// valid/ready pair. The TPW-th tile fire copies the pack buffer plus the
// incoming tile into the word register; word_valid rises the next cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tile_fire    a tile is accepted this cycle
//   tile_data    accepted tile, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   word_ready   downstream accepts word_data this cycle
//   word_valid   word_data holds an unaccepted word
//   word_data    packed word, tile slot k at [k*TILE_W +: TILE_W]
// -----------------------------------------------------------------------------
module ypack_tile_packer
    import ypack_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DATA_W     = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tile_fire,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] tile_data,
    input  logic                            word_ready,
    output logic                            word_valid,
    output logic [DATA_W-1:0]               word_data
);

    localparam int TILE_W   = TILE_SIZE * DATA_WIDTH;
    localparam int TPW      = calc_tpw(DATA_W, TILE_SIZE, DATA_WIDTH);
    localparam int SLOT_W   = (TPW > 1) ? $clog2(TPW) : 1;
    localparam int LAST_LSB = tile_slot_lsb(TPW - 1, TILE_W);

    logic [SLOT_W-1:0] slot_q;
    logic [DATA_W-1:0] pack_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] full_word;
    logic              valid_q;
    logic              last_slot;

    assign last_slot = (slot_q == SLOT_W'(TPW - 1));

    // The last tile goes straight into the word, never through the pack buffer.
    always_comb begin
        // NOTE: assign a default first so no path leaves a bit unassigned (no latch).
        full_word                      = pack_q;
        full_word[LAST_LSB +: TILE_W]  = tile_data;
    end

    // NOTE: the data registers are ordinary flops (not a RAM), so they take the
    // async reset too; this guarantees no residue from an interrupted run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            pack_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (tile_fire) begin
                if (last_slot) begin
                    word_q <= full_word;
                    slot_q <= '0;
                end else begin
                    pack_q[tile_slot_lsb(int'(slot_q), TILE_W) +: TILE_W] <= tile_data;
                    slot_q <= slot_q + SLOT_W'(1);
                end
            end
            // A new word can load in the same cycle the previous one is accepted.
            if (tile_fire && last_slot) begin
                valid_q <= 1'b1;
            end else if (word_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign word_valid = valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/y_axis_pack_writer.sv
// -----------------------------------------------------------------------------
// y_axis_pack_writer
// Sink for the gate-output stream y_t. Packs TILE_SIZE-lane tiles into
// DATA_W-bit words, writes them to the output SRAM bank through a valid/ready
// write port at consecutive addresses (wrapping), and reports per-token and
// per-run completion.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, num_tokens,          run start (sampled in IDLE); token count and
//   base_addr                   first write address latched on start
//   y_axis_TVALID/TREADY/TDATA  tile stream, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mem_wr_en/ready/addr/data   memory write port (valid/ready)
//   busy                        high outside IDLE
//   token_done                  one-cycle pulse after each token's last write
//   done                        one-cycle pulse at run end (FINISH state)
//   checksum                    XOR of all written words (YPACK_CHECKSUM_EN only)
//
// Optional feature: define YPACK_CHECKSUM_EN to add the checksum port.
// -----------------------------------------------------------------------------
module y_axis_pack_writer
    import ypack_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DATA_W     = 256,
    parameter int D          = 256,
    parameter int OUT_ADDR_W = 10,
    parameter int TOK_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [TOK_W-1:0]                num_tokens,
    input  logic [OUT_ADDR_W-1:0]           base_addr,
    input  logic                            y_axis_TVALID,
    output logic                            y_axis_TREADY,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] y_axis_TDATA,
    output logic                            mem_wr_en,
    input  logic                            mem_wr_ready,
    output logic [OUT_ADDR_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]               mem_wr_data,
    output logic                            busy,
    output logic                            token_done,
    output logic                            done
`ifdef YPACK_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]               checksum
`endif
);

    localparam int TPW        = calc_tpw(DATA_W, TILE_SIZE, DATA_WIDTH);
    localparam int TPT        = calc_tpt(D, TILE_SIZE);
    localparam int WPT        = calc_wpt(TPT, TPW);
    localparam int WC_W       = (WPT > 1) ? $clog2(WPT) : 1;
    localparam int TILE_CNT_W = TOK_W + $clog2(TPT + 1);

    state_t                  state_q, state_d;
    logic [TOK_W-1:0]        tokens_q;
    logic [TOK_W-1:0]        tok_cnt_q;
    logic [WC_W-1:0]         word_cnt_q;
    logic [OUT_ADDR_W-1:0]   addr_q;
    logic [TILE_CNT_W-1:0]   tiles_rem_q;
    logic                    token_done_q;

    logic tile_fire;
    logic wr_fire;
    logic word_last;
    logic run_last_write;
    logic start_run;

    assign start_run      = (state_q == IDLE) && start;
    assign wr_fire        = mem_wr_en && mem_wr_ready;
    assign word_last      = (word_cnt_q == WC_W'(WPT - 1));
    assign run_last_write = wr_fire && word_last && (tok_cnt_q == tokens_q - TOK_W'(1));

    // Ready never depends on TVALID; held low while a word is stalled so the
    // word register cannot be overwritten.
    assign y_axis_TREADY = (state_q == RUN) && !(mem_wr_en && !mem_wr_ready)
                           && (tiles_rem_q != '0);
    assign tile_fire     = y_axis_TVALID && y_axis_TREADY;

    ypack_tile_packer #(
        .TILE_SIZE  (TILE_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_W     (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .tile_fire  (tile_fire),
        .tile_data  (y_axis_TDATA),
        .word_ready (mem_wr_ready),
        .word_valid (mem_wr_en),
        .word_data  (mem_wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (num_tokens == '0) ? FINISH : RUN;
            RUN:     if (run_last_write) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tokens_q     <= '0;
            tok_cnt_q    <= '0;
            word_cnt_q   <= '0;
            addr_q       <= '0;
            tiles_rem_q  <= '0;
            token_done_q <= 1'b0;
        end else begin
            token_done_q <= wr_fire && word_last;
            if (start_run) begin
                tokens_q    <= num_tokens;
                addr_q      <= base_addr;
                tiles_rem_q <= TILE_CNT_W'(num_tokens) * TILE_CNT_W'(TPT);
                tok_cnt_q   <= '0;
                word_cnt_q  <= '0;
            end else begin
                if (tile_fire) begin
                    tiles_rem_q <= tiles_rem_q - TILE_CNT_W'(1);
                end
                if (wr_fire) begin
                    addr_q <= addr_q + OUT_ADDR_W'(1);
                    if (word_last) begin
                        word_cnt_q <= '0;
                        tok_cnt_q  <= tok_cnt_q + TOK_W'(1);
                    end else begin
                        word_cnt_q <= word_cnt_q + WC_W'(1);
                    end
                end
            end
        end
    end

`ifdef YPACK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (start_run) begin
            checksum_q <= '0;
        end else if (wr_fire) begin
            checksum_q <= checksum_q ^ mem_wr_data;
        end
    end

    assign checksum = checksum_q;
`endif

    assign mem_wr_addr = addr_q;
    assign busy        = (state_q != IDLE);
    assign token_done  = token_done_q;
    assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_y_axis_pack_writer.sv
// -----------------------------------------------------------------------------
// tb_y_axis_pack_writer
// Directed self-checking bench for y_axis_pack_writer (default parameters:
// 4 tiles/word, 64 tiles/token, 16 words/token, 10-bit addresses).
// Tile t carries lane values t*4+i, so word w carries lane j = w*16+j.
// -----------------------------------------------------------------------------
module tb_y_axis_pack_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  num_tokens;
    logic [9:0]   base_addr;
    logic         y_axis_TVALID;
    logic         y_axis_TREADY;
    logic [63:0]  y_axis_TDATA;
    logic         mem_wr_en;
    logic         mem_wr_ready;
    logic [9:0]   mem_wr_addr;
    logic [255:0] mem_wr_data;
    logic         busy;
    logic         token_done;
    logic         done;
`ifdef YPACK_CHECKSUM_EN
    logic [255:0] checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    y_axis_pack_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_tokens    (num_tokens),
        .base_addr     (base_addr),
        .y_axis_TVALID (y_axis_TVALID),
        .y_axis_TREADY (y_axis_TREADY),
        .y_axis_TDATA  (y_axis_TDATA),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .busy          (busy),
        .token_done    (token_done),
        .done          (done)
`ifdef YPACK_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    function automatic logic [63:0] tile_pattern(int t);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(t * 4 + i);
        return r;
    endfunction

    function automatic logic [255:0] exp_word(int w);
        logic [255:0] r;
        for (int j = 0; j < 16; j++) r[j*16 +: 16] = 16'(w * 16 + j);
        return r;
    endfunction

    // Starts a run and follows it cycle by cycle against a handshake model.
    // stall_word < 0 disables the 5-cycle memory stall.
    task automatic run_stream(input string tag, input int ntok, input logic [9:0] base,
                              input bit bubbles, input int stall_word, input bit glitch_start);
        int          total;
        int          tile_tx, wcount, td_count, stall_cycles, cyc;
        bit          exp_wen, exp_td, exp_done, exp_td_n, exp_done_n, ended, run;
        bit          rdy, exp_tready, fire_t, fire_w;
        logic [9:0]  exp_addr;
        total = ntok * 64;
        tile_tx = 0; wcount = 0; td_count = 0; stall_cycles = 0; cyc = 0;
        exp_wen = 0; exp_td = 0; exp_done = 0; ended = 0; run = 1;

        @(negedge clk);
        start = 1'b1; num_tokens = 16'(ntok); base_addr = base;
        y_axis_TVALID = 1'b0; mem_wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!ended && cyc < 4000) begin
            rdy = !(stall_word >= 0 && wcount == stall_word && stall_cycles < 5);
            mem_wr_ready  = rdy;
            y_axis_TVALID = (tile_tx < total) && (!bubbles || $urandom_range(0, 3) != 0);
            y_axis_TDATA  = tile_pattern(tile_tx);
            start         = glitch_start && (cyc == 20);
            num_tokens    = start ? 16'd7 : 16'(ntok);
            base_addr     = start ? 10'h000 : base;
            #1;
            exp_tready = run && !(exp_wen && !rdy) && (tile_tx < total);

            n_checks++;
            if (mem_wr_en !== exp_wen) begin
                n_fail++;
                $display("FAIL %s mem_wr_en cyc %0d: got %0b expected %0b", tag, cyc, mem_wr_en, exp_wen);
            end
            if (exp_wen) begin
                exp_addr = base + 10'(wcount);
                n_checks++;
                if (mem_wr_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL %s addr word %0d: got %h expected %h", tag, wcount, mem_wr_addr, exp_addr);
                end
                n_checks++;
                if (mem_wr_data !== exp_word(wcount)) begin
                    n_fail++;
                    $display("FAIL %s data word %0d: got %h expected %h", tag, wcount, mem_wr_data, exp_word(wcount));
                end
            end
            n_checks++;
            if (y_axis_TREADY !== exp_tready) begin
                n_fail++;
                $display("FAIL %s TREADY cyc %0d tile %0d: got %0b expected %0b", tag, cyc, tile_tx, y_axis_TREADY, exp_tready);
            end
            n_checks++;
            if (token_done !== exp_td || done !== exp_done || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s status cyc %0d: got td=%0b done=%0b busy=%0b expected td=%0b done=%0b busy=1",
                         tag, cyc, token_done, done, busy, exp_td, exp_done);
            end
            if (token_done === 1'b1) td_count++;

            fire_t     = y_axis_TVALID && exp_tready;
            fire_w     = exp_wen && rdy;
            if (exp_done) ended = 1;
            exp_td_n   = fire_w && (wcount % 16 == 15);
            exp_done_n = exp_td_n && (wcount == total / 4 - 1);
            if (exp_wen && !rdy) stall_cycles++;
            if (fire_w) wcount++;
            if (exp_done_n) run = 0;
            exp_wen = (fire_t && (tile_tx % 4 == 3)) ? 1'b1 : (fire_w ? 1'b0 : exp_wen);
            if (fire_t) tile_tx++;
            exp_td   = exp_td_n;
            exp_done = exp_done_n;

            @(negedge clk);
            cyc++;
        end

        start = 1'b0; y_axis_TVALID = 1'b0; mem_wr_ready = 1'b1;
        #1;
        n_checks++;
        if (!ended) begin
            n_fail++;
            $display("FAIL %s timeout: got no done after %0d cycles, expected done", tag, cyc);
        end
        n_checks++;
        if (wcount != total / 4 || td_count != ntok || tile_tx != total) begin
            n_fail++;
            $display("FAIL %s totals: got writes=%0d token_done=%0d tiles=%0d expected %0d/%0d/%0d",
                     tag, wcount, td_count, tile_tx, total / 4, ntok, total);
        end
        if (stall_word >= 0) begin
            n_checks++;
            if (stall_cycles != 5) begin
                n_fail++;
                $display("FAIL %s stall length: got %0d expected 5", tag, stall_cycles);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_axis_TREADY !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post-run idle: got busy=%0b done=%0b tready=%0b wen=%0b expected all 0",
                     tag, busy, done, y_axis_TREADY, mem_wr_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_tokens = '0; base_addr = '0;
        y_axis_TVALID = 1'b0; y_axis_TDATA = '0; mem_wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({y_axis_TREADY, mem_wr_en, busy, token_done, done} !== 5'b0 ||
            mem_wr_addr !== 10'h0 || mem_wr_data !== 256'h0) begin
            n_fail++;
            $display("FAIL reset state: got tready=%0b wen=%0b busy=%0b td=%0b done=%0b addr=%h data=%h expected all 0",
                     y_axis_TREADY, mem_wr_en, busy, token_done, done, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_stream("basic", 1, 10'h3F0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_stream("wrap", 1, 10'h3F8, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 1, 10'h000, 1'b0, 2, 1'b0);
    endtask

    task automatic test_bubbles();
        run_stream("bubbles", 3, 10'h010, 1'b1, -1, 1'b1);
    endtask

    task automatic test_zero_tokens();
        @(negedge clk);
        start = 1'b1; num_tokens = 16'd0; base_addr = 10'h055;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero start cycle: got busy=%0b done=%0b expected 0/0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_wr_en !== 1'b0 || token_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero done cycle: got done=%0b busy=%0b wen=%0b td=%0b expected 1/1/0/0",
                     done, busy, mem_wr_en, token_done);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero after: got done=%0b busy=%0b wen=%0b expected 0/0/0", done, busy, mem_wr_en);
        end
    endtask

    task automatic test_reset_mid_run();
        int fired, guard;
        fired = 0; guard = 0;
        @(negedge clk);
        start = 1'b1; num_tokens = 16'd1; base_addr = 10'h100; mem_wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (fired < 6 && guard < 50) begin
            y_axis_TVALID = 1'b1;
            y_axis_TDATA  = {4{16'hF000 | 16'(fired)}};
            #1;
            if (y_axis_TREADY) fired++;
            @(negedge clk);
            guard++;
        end
        y_axis_TVALID = 1'b0;
        #1;
        n_checks++;
        if (fired != 6 || busy !== 1'b1 || mem_wr_addr !== 10'h101) begin
            n_fail++;
            $display("FAIL mid-run setup: got tiles=%0d busy=%0b addr=%h expected 6/1/101", fired, busy, mem_wr_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({y_axis_TREADY, mem_wr_en, busy, token_done, done} !== 5'b0 ||
            mem_wr_addr !== 10'h0 || mem_wr_data !== 256'h0) begin
            n_fail++;
            $display("FAIL mid-run reset: got tready=%0b wen=%0b busy=%0b td=%0b done=%0b addr=%h data=%h expected all 0",
                     y_axis_TREADY, mem_wr_en, busy, token_done, done, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_stream("after_reset", 1, 10'h000, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_zero_tokens();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
